dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
Shares the single data-memory port of the byte-banked SRAM interface between two requesters: the CPU load/store unit and the debug/UART loader. Grants at most one access per cycle, with CPU priority, a starvation guard for the debug side, and an optional bounded debug lock for bursts. Generates the 4-bit byte write-enable mask from the store control code and address alignment. Returns read data one cycle after grant, tagged to the owning requester.

Parameters:
MAX_WAIT, 8, debug wait cycles (while requesting, not granted) before debug overrides CPU priority; >=1
LOCK_MAX, 16, max consecutive locked debug grants before the CPU is forced one grant; >=1
CNT_W, 5, width of the wait and lock counters; must hold max(MAX_WAIT, LOCK_MAX)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-high
cpu_req  in  1  CPU access request, held until cpu_gnt
cpu_addr  in  32  CPU byte address
cpu_din  in  32  CPU store data
cpu_store  in  3  001 byte, 010 halfword, 100 word; any other value = read
cpu_gnt  out  1  CPU access issued to memory this cycle
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  32  CPU read data
dbg_req  in  1  debug access request, held until dbg_gnt
dbg_lock  in  1  sampled with dbg_gnt; 1 = keep ownership for next access
dbg_addr  in  32  debug byte address
dbg_din  in  32  debug store data
dbg_store  in  3  same encoding as cpu_store
dbg_gnt  out  1  debug access issued this cycle
dbg_rvalid  out  1  debug read data valid
dbg_rdata  out  32  debug read data
mem_en  out  1  memory port enable
mem_addr  out  32  memory byte address
mem_din  out  32  memory write data (unrotated; interface performs lane rotation)
mem_storecntrl  out  3  store code forwarded to memory
mem_wen  out  4  per-bank byte write enable
mem_dout  in  32  memory read data, valid the cycle after mem_en

Behaviour:
- Grant is combinational from requests and registered state; at most one of cpu_gnt/dbg_gnt high.
- Only one requesting: that requester granted.
- Both requesting, priority order: (1) lock_r=1 and lock_cnt<LOCK_MAX -> debug; (2) lock_r=1 and lock_cnt==LOCK_MAX -> CPU; (3) wait_cnt==MAX_WAIT -> debug; (4) otherwise CPU.
- wait_cnt: +1 when dbg_req & !dbg_gnt, saturates at MAX_WAIT; cleared on dbg_gnt or !dbg_req.
- lock_r: set on dbg_gnt & dbg_lock; cleared on dbg_gnt & !dbg_lock, on !dbg_req, or on a forced CPU grant (case 2).
- lock_cnt: +1 per locked debug grant; cleared whenever lock_r clears.
- mem_en = cpu_gnt | dbg_gnt. mem_addr/mem_din/mem_storecntrl come from the winner; when idle, all are 0.
- mem_wen (0 when idle), by code and mem_addr[1:0] (00/01/10/11):
  - byte: 0001/0010/0100/1000
  - half: 0011/0110/1100/1001 (wrap)
  - word: 1111 regardless of alignment
  - read: 0000
- Read return: when a granted access is a read, register owner and pend; next cycle assert owner's rvalid for exactly 1 cycle with rdata = mem_dout.
- Non-asserted rdata = 0. Writes produce no rvalid.
- Back-to-back reads by either requester are allowed every cycle (throughput 1/cycle).
- Reset (any cycle): wait_cnt, lock_cnt, lock_r, and pending read all cleared; no grant or mem_en during the reset cycle; rvalid of a read granted in the cycle before reset is suppressed; all outputs 0.

Test Plan:
- Reset: assert rst with both requests high -> all outputs 0 during reset; first cycle after reset with both requests -> cpu_gnt=1.
- Alignment masks: dbg only, dbg_store=010, dbg_addr=0x103 -> mem_wen=1001, mem_addr=0x103; dbg_store=001, addr 0x102 -> mem_wen=0100; dbg_store=100, addr 0x101 -> mem_wen=1111.
- Read latency: cpu read at 0x40 granted in cycle N, mem_dout=0xDEADBEEF in N+1 -> cpu_rvalid=1 and cpu_rdata=0xDEADBEEF in N+1 only; dbg_rvalid=0 throughout.
- Starvation: cpu_req and dbg_req held continuously, MAX_WAIT=8 -> CPU granted for 8 cycles, debug granted on 9th cycle, CPU granted again on 10th.
- Lock bound: dbg_lock=1, both requesting, LOCK_MAX=16 -> 16 consecutive dbg grants, then 1 cpu grant; debug then contends normally.
- Reset mid-read: dbg read granted in cycle N, rst=1 in N+1 -> dbg_rvalid stays 0; lock and wait state cleared.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: CPU vs debug loader, byte-lane write
// enables, and tagged one-cycle read return.
module dmem_port_arbiter #(
   parameter int MAX_WAIT = 8,
   parameter int LOCK_MAX = 16,
   parameter int CNT_W    = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_din,
   input  logic [2:0]  cpu_store,
   output logic        cpu_gnt,
   output logic        cpu_rvalid,
   output logic [31:0] cpu_rdata,
   input  logic        dbg_req,
   input  logic        dbg_lock,
   input  logic [31:0] dbg_addr,
   input  logic [31:0] dbg_din,
   input  logic [2:0]  dbg_store,
   output logic        dbg_gnt,
   output logic        dbg_rvalid,
   output logic [31:0] dbg_rdata,
   output logic        mem_en,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   output logic [2:0]  mem_storecntrl,
   output logic [3:0]  mem_wen,
   input  logic [31:0] mem_dout
);

   localparam logic [CNT_W-1:0] C_MAX_WAIT = CNT_W'(MAX_WAIT);
   localparam logic [CNT_W-1:0] C_LOCK_MAX = CNT_W'(LOCK_MAX);

   logic [CNT_W-1:0] r_wait_cnt;
   logic [CNT_W-1:0] r_lock_cnt;
   logic             r_lock;
   logic             r_pend;
   logic             r_owner;

   logic             w_both;
   logic             w_lock_ok;
   logic             w_forced;
   logic             w_dbg_win;
   logic             w_cpu_gnt;
   logic             w_dbg_gnt;
   logic             w_is_read;
   logic [CNT_W-1:0] w_wait_nxt;
   logic [CNT_W-1:0] w_lock_cnt_nxt;
   logic             w_lock_nxt;

   // Grant decision: CPU priority, bounded debug lock, starvation override
   always_comb begin
      w_both    = cpu_req & dbg_req;
      w_lock_ok = r_lock & (r_lock_cnt < C_LOCK_MAX);
      w_forced  = w_both & r_lock & ~w_lock_ok;
      w_dbg_win = w_both &
                  (w_lock_ok | (~r_lock & (r_wait_cnt == C_MAX_WAIT)));
      w_dbg_gnt = ~rst & dbg_req & (~cpu_req | w_dbg_win);
      w_cpu_gnt = ~rst & cpu_req & ~(dbg_req & w_dbg_win);
   end

   assign cpu_gnt = w_cpu_gnt;
   assign dbg_gnt = w_dbg_gnt;
   assign mem_en  = w_cpu_gnt | w_dbg_gnt;

   // Route the winner's address, data and store code onto the port
   always_comb begin
      mem_addr       = '0;
      mem_din        = '0;
      mem_storecntrl = '0;
      if (w_cpu_gnt) begin
         mem_addr       = cpu_addr;
         mem_din        = cpu_din;
         mem_storecntrl = cpu_store;
      end else if (w_dbg_gnt) begin
         mem_addr       = dbg_addr;
         mem_din        = dbg_din;
         mem_storecntrl = dbg_store;
      end
   end

   // Byte-bank write enables from store size and address alignment
   always_comb begin
      mem_wen   = 4'b0000;
      w_is_read = 1'b1;
      unique case (mem_storecntrl)
         3'b001: begin
            w_is_read = 1'b0;
            mem_wen   = 4'b0001 << mem_addr[1:0];
         end
         3'b010: begin
            w_is_read = 1'b0;
            unique case (mem_addr[1:0])
               2'b00: mem_wen = 4'b0011;
               2'b01: mem_wen = 4'b0110;
               2'b10: mem_wen = 4'b1100;
               2'b11: mem_wen = 4'b1001;
            endcase
         end
         3'b100: begin
            w_is_read = 1'b0;
            mem_wen   = 4'b1111;
         end
         default: begin
            w_is_read = 1'b1;
            mem_wen   = 4'b0000;
         end
      endcase
      if (!mem_en) begin
         mem_wen = 4'b0000;
      end
   end

   // Next values of the starvation counter and the debug lock
   always_comb begin
      w_wait_nxt     = r_wait_cnt;
      w_lock_nxt     = r_lock;
      w_lock_cnt_nxt = r_lock_cnt;
      if (!dbg_req || w_dbg_gnt) begin
         w_wait_nxt = '0;
      end else if (r_wait_cnt != C_MAX_WAIT) begin
         w_wait_nxt = r_wait_cnt + 1'b1;
      end
      if (w_dbg_gnt) begin
         w_lock_nxt = dbg_lock;
      end else if (!dbg_req) begin
         w_lock_nxt = 1'b0;
      end else if (w_cpu_gnt && w_forced) begin
         w_lock_nxt = 1'b0;
      end
      if (!w_lock_nxt) begin
         w_lock_cnt_nxt = '0;
      end else if (w_dbg_gnt && dbg_lock &&
                   (r_lock_cnt != C_LOCK_MAX)) begin
         w_lock_cnt_nxt = r_lock_cnt + 1'b1;
      end
   end

   // Arbitration state and pending read tag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wait_cnt <= '0;
         r_lock_cnt <= '0;
         r_lock     <= 1'b0;
         r_pend     <= 1'b0;
         r_owner    <= 1'b0;
      end else begin
         r_wait_cnt <= w_wait_nxt;
         r_lock_cnt <= w_lock_cnt_nxt;
         r_lock     <= w_lock_nxt;
         r_pend     <= mem_en & w_is_read;
         r_owner    <= w_dbg_gnt;
      end
   end

   // Return read data to the requester that owned the access
   always_comb begin
      cpu_rvalid = r_pend & ~r_owner & ~rst;
      dbg_rvalid = r_pend & r_owner & ~rst;
      cpu_rdata  = cpu_rvalid ? mem_dout : 32'h0;
      dbg_rdata  = dbg_rvalid ? mem_dout : 32'h0;
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a read-return scoreboard.
module tb_dmem_port_arbiter;

   logic        clk;
   logic        rst;
   logic        cpu_req;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_din;
   logic [2:0]  cpu_store;
   logic        cpu_gnt;
   logic        cpu_rvalid;
   logic [31:0] cpu_rdata;
   logic        dbg_req;
   logic        dbg_lock;
   logic [31:0] dbg_addr;
   logic [31:0] dbg_din;
   logic [2:0]  dbg_store;
   logic        dbg_gnt;
   logic        dbg_rvalid;
   logic [31:0] dbg_rdata;
   logic        mem_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic [2:0]  mem_storecntrl;
   logic [3:0]  mem_wen;
   logic [31:0] mem_dout;

   int n_err;
   int n_chk;
   bit dout_fix;
   bit sb[$];

   dmem_port_arbiter #(
      .MAX_WAIT(8),
      .LOCK_MAX(16),
      .CNT_W(5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cpu_req(cpu_req),
      .cpu_addr(cpu_addr),
      .cpu_din(cpu_din),
      .cpu_store(cpu_store),
      .cpu_gnt(cpu_gnt),
      .cpu_rvalid(cpu_rvalid),
      .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req),
      .dbg_lock(dbg_lock),
      .dbg_addr(dbg_addr),
      .dbg_din(dbg_din),
      .dbg_store(dbg_store),
      .dbg_gnt(dbg_gnt),
      .dbg_rvalid(dbg_rvalid),
      .dbg_rdata(dbg_rdata),
      .mem_en(mem_en),
      .mem_addr(mem_addr),
      .mem_din(mem_din),
      .mem_storecntrl(mem_storecntrl),
      .mem_wen(mem_wen),
      .mem_dout(mem_dout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [3:0] wen_model(input logic [2:0] c,
                                            input logic [1:0] a);
      logic [3:0] w;
      w = 4'h0;
      case (c)
         3'b001:
            case (a)
               2'd0: w = 4'h1;
               2'd1: w = 4'h2;
               2'd2: w = 4'h4;
               default: w = 4'h8;
            endcase
         3'b010:
            case (a)
               2'd0: w = 4'h3;
               2'd1: w = 4'h6;
               2'd2: w = 4'hC;
               default: w = 4'h9;
            endcase
         3'b100: w = 4'hF;
         default: w = 4'h0;
      endcase
      return w;
   endfunction

   function automatic bit is_rd(input logic [2:0] c);
      return !(c == 3'b001 || c == 3'b010 || c == 3'b100);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: check grants, read return and port contents
   task automatic tick(input string tag, input bit ecg, input bit edg);
      logic [31:0] ea;
      logic [31:0] ed;
      logic [2:0]  es;
      logic [3:0]  ew;
      bit          een;
      bit          pv;
      bit          own;
      if (!dout_fix) mem_dout = $urandom();
      @(negedge clk);
      chk({tag, ":cpu_gnt"}, 32'(cpu_gnt), 32'(ecg));
      chk({tag, ":dbg_gnt"}, 32'(dbg_gnt), 32'(edg));
      pv  = 1'b0;
      own = 1'b0;
      if (sb.size() > 0) begin
         own = sb.pop_front();
         pv  = !rst;
      end
      chk({tag, ":cpu_rvalid"}, 32'(cpu_rvalid), 32'(pv && !own));
      chk({tag, ":dbg_rvalid"}, 32'(dbg_rvalid), 32'(pv && own));
      chk({tag, ":cpu_rdata"}, cpu_rdata,
          (pv && !own) ? mem_dout : 32'h0);
      chk({tag, ":dbg_rdata"}, dbg_rdata,
          (pv && own) ? mem_dout : 32'h0);
      een = ecg || edg;
      ea  = ecg ? cpu_addr : (edg ? dbg_addr : 32'h0);
      ed  = ecg ? cpu_din : (edg ? dbg_din : 32'h0);
      es  = ecg ? cpu_store : (edg ? dbg_store : 3'b000);
      ew  = een ? wen_model(es, ea[1:0]) : 4'h0;
      chk({tag, ":mem_en"}, 32'(mem_en), 32'(een));
      chk({tag, ":mem_addr"}, mem_addr, ea);
      chk({tag, ":mem_din"}, mem_din, ed);
      chk({tag, ":mem_store"}, 32'(mem_storecntrl), 32'(es));
      chk({tag, ":mem_wen"}, 32'(mem_wen), 32'(ew));
      if (een && is_rd(es)) sb.push_back(edg);
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_err     = 0;
      n_chk     = 0;
      dout_fix  = 1'b0;
      rst       = 1'b1;
      cpu_req   = 1'b1;
      cpu_addr  = 32'h0000_0040;
      cpu_din   = 32'h1111_2222;
      cpu_store = 3'b000;
      dbg_req   = 1'b1;
      dbg_lock  = 1'b0;
      dbg_addr  = 32'h0000_0103;
      dbg_din   = 32'h3333_4444;
      dbg_store = 3'b000;
      mem_dout  = 32'h0;

      tick("rst0", 1'b0, 1'b0);
      tick("rst1", 1'b0, 1'b0);
      rst = 1'b0;
      tick("post_rst", 1'b1, 1'b0);

      cpu_req   = 1'b0;
      dbg_store = 3'b010;
      dbg_addr  = 32'h0000_0103;
      tick("half_wrap", 1'b0, 1'b1);
      dbg_store = 3'b001;
      dbg_addr  = 32'h0000_0102;
      tick("byte_2", 1'b0, 1'b1);
      dbg_store = 3'b100;
      dbg_addr  = 32'h0000_0101;
      tick("word_1", 1'b0, 1'b1);

      dbg_req   = 1'b0;
      cpu_req   = 1'b1;
      cpu_store = 3'b000;
      cpu_addr  = 32'h0000_0040;
      tick("rd_issue", 1'b1, 1'b0);
      cpu_req  = 1'b0;
      dout_fix = 1'b1;
      mem_dout = 32'hDEAD_BEEF;
      tick("rd_ret", 1'b0, 1'b0);
      mem_dout = 32'h0BAD_F00D;
      tick("rd_after", 1'b0, 1'b0);
      dout_fix = 1'b0;

      cpu_req   = 1'b1;
      dbg_req   = 1'b1;
      cpu_store = 3'b100;
      cpu_addr  = 32'h0000_0202;
      dbg_store = 3'b000;
      dbg_addr  = 32'h0000_0300;
      for (int i = 0; i < 8; i++) tick("starve_cpu", 1'b1, 1'b0);
      tick("starve_dbg", 1'b0, 1'b1);
      tick("starve_back", 1'b1, 1'b0);

      rst = 1'b1;
      tick("rst_lock", 1'b0, 1'b0);
      rst       = 1'b0;
      dbg_lock  = 1'b1;
      cpu_store = 3'b000;
      for (int i = 0; i < 8; i++) tick("lk_pre_cpu", 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) tick("lk_dbg", 1'b0, 1'b1);
      tick("lk_forced_cpu", 1'b1, 1'b0);
      dbg_lock = 1'b0;
      for (int i = 0; i < 7; i++) tick("lk_norm_cpu", 1'b1, 1'b0);
      tick("lk_norm_dbg", 1'b0, 1'b1);
      tick("lk_norm_cpu2", 1'b1, 1'b0);

      rst = 1'b1;
      tick("rst_a0", 1'b0, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) tick("wa_cpu", 1'b1, 1'b0);
      rst = 1'b1;
      tick("rst_a1", 1'b0, 1'b0);
      rst = 1'b0;
      tick("wait_clr", 1'b1, 1'b0);

      cpu_req   = 1'b0;
      dbg_lock  = 1'b1;
      dbg_store = 3'b000;
      tick("mid_rd", 1'b0, 1'b1);
      rst = 1'b1;
      tick("mid_rst", 1'b0, 1'b0);
      rst      = 1'b0;
      dbg_lock = 1'b0;
      cpu_req  = 1'b1;
      tick("lock_clr", 1'b1, 1'b0);
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      tick("idle", 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
